// File: rtl/mmio_lcd_ctrl.sv
// rtl/mmio_lcd_ctrl.sv - Memory-mapped HD44780-style character-LCD controller
//
// The CPU pushes data or command bytes into a write FIFO. An FSM pops each
// entry and drives the RS, data and E waveforms with programmable setup,
// pulse, hold and gap timing. Both 8-bit and 4-bit buses are supported. In
// 4-bit mode a byte goes out as the high nibble and then the low nibble.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sel            peripheral select (address decoded upstream)
//   addr[3:0]      byte offset; only addr[3:2] is decoded
//   wdata[31:0]    write data
//   wenable[3:0]   byte strobes; a write occurs when sel && wenable[0]
//   rdata[31:0]    read data, combinational from addr[3:2]
//   lcd_data       LCD data bus (DATA_W bits)
//   lcd_rs         register select (1 = data, 0 = command)
//   lcd_enable     LCD E strobe
//   busy           FIFO non-empty or transfer/gap in progress
//
// Register map (addr[3:2]):
//   0 DATA   write: push {rs=1, wdata[7:0]}
//   1 CMD    write: push {rs=0, wdata[7:0]}
//   2 STATUS read : bit0 busy, bit1 full, bit2 empty, bit3 overflow,
//                   bits[15:8] FIFO level
//   3 CTRL   write: bit0 flush FIFO, bit1 clear overflow
//
// Optional macro LCD_SIM_PRINT_EN: a simulation-only block that echoes each
// completed data byte (rs=1) with $write. It does not affect any port.

module mmio_lcd_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 4,
    parameter int HOLD_CYC   = 2,
    parameter int GAP_CYC    = 16,
    parameter int LONG_CYC   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [3:0]        addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wenable,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_rs,
    output logic              lcd_enable,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       push_req;
    logic       push_rs;
    logic       ctrl_wr;
    logic       flush;
    logic       ovf_clr;

    assign reg_sel  = addr[3:2];
    assign wr_en    = sel && wenable[0];
    assign push_req = wr_en && ((reg_sel == 2'd0) || (reg_sel == 2'd1));
    assign push_rs  = (reg_sel == 2'd0);
    assign ctrl_wr  = wr_en && (reg_sel == 2'd3);
    assign flush    = ctrl_wr && wdata[0];
    assign ovf_clr  = ctrl_wr && wdata[1];

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], wenable[3:1], addr[1:0]};

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    logic [8:0]       fifo_rdata;

    state_t state_q, state_d;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_rdata = mem[rd_ptr_q];

    // A flush suppresses the pop so the flushed entries are never sent.
    assign pop       = (state_q == ST_IDLE) && !fifo_empty && !flush;
    // A same-cycle pop frees a slot, so a push into a full FIFO is accepted.
    assign push_ok   = push_req && !flush && (!fifo_full || pop);
    assign push_drop = push_req && !flush && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // The storage array needs no reset; the level counter qualifies it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {push_rs, wdata[7:0]};
        end
    end

    // ------------------------------------------------------------------
    // LCD waveform FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [8:0]        cur_q, cur_d;
    logic              nib_q, nib_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rs_q, rs_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] low_word;
    logic              is_long;
    logic [CNT_W-1:0]  gap_len;

    generate
        if (DATA_W == 4) begin : g_nibble
            assign first_word = fifo_rdata[7:4];
            assign low_word   = cur_q[3:0];
        end else begin : g_byte
            assign first_word = fifo_rdata[7:0];
            assign low_word   = cur_q[7:0];
        end
    endgenerate

    // Clear and home need the long execution time on the LCD side.
    assign is_long = !cur_q[8] && ((cur_q[7:0] == 8'h01) || (cur_q[7:0] == 8'h02));
    assign gap_len = is_long ? CNT_W'(LONG_CYC) : CNT_W'(GAP_CYC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        nib_d   = nib_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cur_d   = fifo_rdata;
                    rs_d    = fifo_rdata[8];
                    data_d  = first_word;
                    nib_d   = 1'b0;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                en_d = 1'b1;
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if ((DATA_W == 4) && !nib_q) begin
                        // Second nibble goes straight out with no gap.
                        nib_d   = 1'b1;
                        data_d  = low_word;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                        state_d = ST_SETUP;
                    end else if (gap_len == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = gap_len - 1'b1;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) || (level_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            nib_q   <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            nib_q   <= nib_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_enable = en_q;
    assign busy       = busy_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (reg_sel == 2'd2) begin
            rdata = {16'h0000, 8'(level_q), 4'h0, ovf_q, fifo_empty, fifo_full, busy_q};
        end
    end

`ifdef LCD_SIM_PRINT_EN
    // Echo a data byte when the E pulse that completes it falls.
    always @(posedge clk) begin
        if (rst_n && (state_q == ST_PULSE) && (state_d == ST_HOLD) && cur_q[8] &&
            ((DATA_W != 4) || nib_q)) begin
            $write("%c", cur_q[7:0]);
        end
    end
`else
`endif

endmodule

// File: tb/tb_mmio_lcd_ctrl.sv
// tb/tb_mmio_lcd_ctrl.sv - Self-checking bench for mmio_lcd_ctrl (8-bit and 4-bit)

module tb_mmio_lcd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sel8, sel4;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wenable;
    logic [31:0] rdata8, rdata4;
    logic [7:0]  data8;
    logic [3:0]  data4;
    logic        rs8, rs4, en8, en4, busy8, busy4;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses8 = 0;
    int pulses4 = 0;

    mmio_lcd_ctrl #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .sel(sel8), .addr(addr), .wdata(wdata),
        .wenable(wenable), .rdata(rdata8), .lcd_data(data8), .lcd_rs(rs8),
        .lcd_enable(en8), .busy(busy8)
    );

    mmio_lcd_ctrl #(.DATA_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .sel(sel4), .addr(addr), .wdata(wdata),
        .wenable(wenable), .rdata(rdata4), .lcd_data(data4), .lcd_rs(rs4),
        .lcd_enable(en4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge en8) pulses8 = pulses8 + 1;
    always @(posedge en4) pulses4 = pulses4 + 1;

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       rs;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t v8[8];
    vec_t v4[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit four, input logic [3:0] a, input logic [31:0] d);
        sel8    = !four;
        sel4    = four;
        addr    = a;
        wdata   = d;
        wenable = 4'h1;
        @(posedge clk);
        #1;
        sel8    = 1'b0;
        sel4    = 1'b0;
        wenable = 4'h0;
        wdata   = '0;
    endtask

    task automatic rd(input bit four, input logic [3:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = four ? rdata4 : rdata8;
        addr = 4'h0;
    endtask

    task automatic wait_idle(input bit four, input int maxc);
        int c;
        c = 0;
        while ((four ? busy4 : busy8) && (c < maxc)) begin
            step(1);
            c++;
        end
        chk(four ? "idle4_timeout" : "idle8_timeout", {31'b0, four ? busy4 : busy8}, 32'h0);
    endtask

    initial begin
        logic [31:0] st;
        int base;
        int c;

        v8[0] = '{0,  8'h00, 1'b0, 1'b0, 1'b1};
        v8[1] = '{1,  8'h41, 1'b1, 1'b0, 1'b1};
        v8[2] = '{2,  8'h41, 1'b1, 1'b0, 1'b1};
        v8[3] = '{3,  8'h41, 1'b1, 1'b1, 1'b1};
        v8[4] = '{6,  8'h41, 1'b1, 1'b1, 1'b1};
        v8[5] = '{7,  8'h41, 1'b1, 1'b0, 1'b1};
        v8[6] = '{24, 8'h41, 1'b1, 1'b0, 1'b1};
        v8[7] = '{25, 8'h41, 1'b1, 1'b0, 1'b0};

        v4[0]  = '{1,  8'h02, 1'b0, 1'b0, 1'b1};
        v4[1]  = '{3,  8'h02, 1'b0, 1'b1, 1'b1};
        v4[2]  = '{6,  8'h02, 1'b0, 1'b1, 1'b1};
        v4[3]  = '{7,  8'h02, 1'b0, 1'b0, 1'b1};
        v4[4]  = '{8,  8'h02, 1'b0, 1'b0, 1'b1};
        v4[5]  = '{9,  8'h08, 1'b0, 1'b0, 1'b1};
        v4[6]  = '{10, 8'h08, 1'b0, 1'b0, 1'b1};
        v4[7]  = '{11, 8'h08, 1'b0, 1'b1, 1'b1};
        v4[8]  = '{14, 8'h08, 1'b0, 1'b1, 1'b1};
        v4[9]  = '{15, 8'h08, 1'b0, 1'b0, 1'b1};
        v4[10] = '{32, 8'h08, 1'b0, 1'b0, 1'b1};
        v4[11] = '{33, 8'h08, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; sel8 = 1'b0; sel4 = 1'b0;
        addr = 4'h0; wdata = '0; wenable = 4'h0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Reset / idle
        rd(1'b0, 4'h8, st); chk("rst_status8", st, 32'h0000_0004);
        rd(1'b1, 4'h8, st); chk("rst_status4", st, 32'h0000_0004);
        chk("rst_outs8", {data8, rs8, en8, busy8}, 32'h0);
        chk("rst_outs4", {data4, rs4, en4, busy4}, 32'h0);
        rd(1'b0, 4'h0, st); chk("rd_data_off", st, 32'h0);

        // 8-bit DATA 0x41 waveform
        base = pulses8;
        wr(1'b0, 4'h0, 32'h0000_0041);
        for (int k = 0; k <= 25; k++) begin
            if (k > 0) step(1);
            for (int i = 0; i < 8; i++) begin
                if (v8[i].k == k) begin
                    chk($sformatf("w8_k%0d", k), {data8, rs8, en8, busy8},
                        {v8[i].data, v8[i].rs, v8[i].en, v8[i].busy});
                end
            end
        end
        chk("w8_pulses", pulses8 - base, 1);

        // 4-bit CMD 0x28
        base = pulses4;
        wr(1'b1, 4'h4, 32'h0000_0028);
        for (int k = 1; k <= 33; k++) begin
            step(1);
            for (int i = 0; i < 12; i++) begin
                if (v4[i].k == k) begin
                    chk($sformatf("w4_k%0d", k), {data4, rs4, en4, busy4},
                        {v4[i].data[3:0], v4[i].rs, v4[i].en, v4[i].busy});
                end
            end
        end
        chk("w4_pulses", pulses4 - base, 2);

        // Long command: clear, then 'H'
        wr(1'b0, 4'h4, 32'h0000_0001);
        wr(1'b0, 4'h0, 32'h0000_0048);
        chk("long_first", {data8, rs8}, {8'h01, 1'b0});
        step(72);
        chk("long_gap_end", {data8, rs8, en8, busy8}, {8'h01, 1'b0, 1'b0, 1'b1});
        step(1);
        chk("long_next_pop", {data8, rs8}, {8'h48, 1'b1});
        wait_idle(1'b0, 200);

        // Overflow and flush
        base = pulses8;
        for (int i = 0; i < 10; i++) wr(1'b0, 4'h0, 32'h60 + i);
        rd(1'b0, 4'h8, st); chk("ovf_status", st, 32'h0000_080B);
        wr(1'b0, 4'hC, 32'h0000_0003);
        rd(1'b0, 4'h8, st); chk("flush_status", st, 32'h0000_0005);
        wait_idle(1'b0, 200);
        chk("flush_pulses", pulses8 - base, 1);
        chk("flush_last_byte", data8, 8'h60);
        rd(1'b0, 4'h8, st); chk("flush_idle_status", st, 32'h0000_0004);

        // Async reset in the middle of PULSE
        wr(1'b0, 4'h0, 32'h0000_0055);
        wr(1'b0, 4'h0, 32'h0000_0056);
        c = 0;
        while (!en8 && c < 20) begin
            step(1);
            c++;
        end
        chk("pre_reset_e_high", {31'b0, en8}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {data8, rs8, en8, busy8}, 32'h0);
        step(2);
        rst_n = 1'b1;
        rd(1'b0, 4'h8, st); chk("post_reset_status", st, 32'h0000_0004);
        wr(1'b0, 4'h0, 32'h0000_005A);
        step(1);
        chk("post_reset_data", {data8, rs8, en8}, {8'h5A, 1'b1, 1'b0});
        step(2);
        chk("post_reset_e", {31'b0, en8}, 32'h1);
        wait_idle(1'b0, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_lcd_ctrl.md
Name: mmio_lcd_ctrl

Overview:
Memory-mapped character-LCD controller (HD44780-style) for the CPU bus.
- Replaces hand-toggled data/ctrl/enable registers: the CPU pushes data or command bytes into a FIFO.
- The controller generates the RS, data and E waveforms autonomously with programmable setup, pulse, hold and gap timing.
- Supports 8-bit or 4-bit bus mode. Sits on the peripheral side of the address decode, in the clk domain.

Parameters:
DATA_W, 8, LCD bus width; 8 or 4 only. In 4-bit mode each byte is sent as high nibble then low nibble.
FIFO_DEPTH, 8, entries in the write FIFO; power of 2, >= 2.
SETUP_CYC, 2, clk cycles that data/RS are stable before E rises; >= 1.
PULSE_CYC, 4, clk cycles E is high; >= 1.
HOLD_CYC, 2, clk cycles data is held after E falls; >= 1.
GAP_CYC, 16, idle cycles after a byte before the next pop.
LONG_CYC, 64, gap used instead of GAP_CYC after commands 0x01 (clear) and 0x02 (home).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sel  in  1  peripheral select (address decoded upstream)
addr  in  4  byte offset; word-aligned, only addr[3:2] is used
wdata  in  32  write data
wenable  in  4  byte write strobes; a write occurs when sel && wenable[0]
rdata  out  32  read data, combinational from addr[3:2]
lcd_data  out  DATA_W  LCD data bus
lcd_rs  out  1  register select (1 = data, 0 = command)
lcd_enable  out  1  LCD E strobe
busy  out  1  high when FIFO non-empty or FSM not IDLE

Behaviour:
Reset:
- rst_n is asynchronous, active-low; clock is clk.
- On reset: FIFO emptied, FSM set to IDLE, overflow flag cleared, lcd_data=0, lcd_rs=0, lcd_enable=0, busy=0.
- Reset asserted mid-transfer aborts the transfer immediately, with no E completion.

Register map (addr[3:2]):
- 0 DATA (write): push {rs=1, wdata[7:0]}.
- 1 CMD (write): push {rs=0, wdata[7:0]}.
- 2 STATUS (read): bit0 busy, bit1 full, bit2 empty, bit3 overflow; bits[15:8] FIFO level; all other bits 0.
- 3 CTRL (write): bit0=1 flushes the FIFO; bit1=1 clears overflow.
- Writes to STATUS are ignored. Reads of other offsets return 0.

FIFO:
- 9-bit entries; level counter ranges 0..FIFO_DEPTH.
- Push while full: entry dropped, overflow set (sticky), level unchanged.
- Push and pop in the same cycle: level unchanged; legal when full (the pop frees the slot first) and when empty only if no pop occurs.
- Flush empties the FIFO next cycle but does not abort the byte in flight. A flush and a push in the same cycle: flush wins and the push is discarded.

FSM states: IDLE, SETUP, PULSE, HOLD, GAP.
- IDLE: if FIFO non-empty, pop and latch the entry. Next cycle enter SETUP with lcd_rs and lcd_data driven (8-bit: the byte; 4-bit: byte[7:4]).
- SETUP: E=0 for SETUP_CYC cycles, then PULSE.
- PULSE: E=1 for PULSE_CYC cycles, then HOLD.
- HOLD: E=0 with data unchanged for HOLD_CYC cycles.
  - In 4-bit mode after the first nibble: load byte[3:0] and return to SETUP.
  - Otherwise go to GAP.
- GAP: wait LONG_CYC if the entry was rs=0 with byte 0x01 or 0x02, else GAP_CYC; then IDLE. A gap of 0 goes to IDLE immediately.
- lcd_data and lcd_rs hold their last values in IDLE and GAP.

Timing and outputs:
- All outputs are registered. E rises exactly SETUP_CYC cycles after data changes.
- Throughput in 8-bit mode with GAP_CYC=G: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC + G cycles per byte.

Optional Feature:
LCD_SIM_PRINT_EN
- Defined: simulation-only block. On each falling edge of lcd_enable where the completed byte had rs=1, it calls $write("%c", byte). In 4-bit mode it prints once per byte, after the second nibble. It has no effect on synthesis or on any port.
- Not defined: no print logic is compiled; behaviour is otherwise identical.

Test Plan:
- Reset/idle: reset, then read STATUS -> rdata=0x00000004 (empty); lcd_enable=0, lcd_rs=0, lcd_data=0, busy=0.
- 8-bit DATA write, defaults: write 0x41 to DATA -> lcd_rs=1 and lcd_data=0x41 one cycle after the pop; E high for exactly 4 cycles starting 2 cycles later; busy drops 1+2+4+2+16 = 25 cycles after the pop.
- 4-bit CMD 0x28 (DATA_W=4): two E pulses, lcd_data=0x2 then 0x8, lcd_rs=0 on both; GAP_CYC applies after the second nibble only.
- Long command: write 0x01 to CMD, then 0x48 to DATA -> 64 idle cycles between the first E fall+HOLD and the next pop.
- Overflow/flush: 10 DATA writes back-to-back, DEPTH=8, FSM stalled on the first byte -> STATUS overflow=1, full=1, level=8. The first popped byte completes its E pulse. Write CTRL=0x3 -> level=0, overflow=0, no further E pulses.
- Async reset mid-PULSE: assert rst_n=0 while E=1 -> lcd_enable=0 immediately (no clock edge needed), FIFO empty after release, next write starts from IDLE.
